spi_command_sequencer: RTL and testbench

- Upstream feeder for spi_master. Replaces the single-shot driver with a table-driven sequencer.
- On a start pulse it walks a command table held in an external synchronous ROM, one entry per step.
- Each entry is either an SPI transfer or a wait.
- It drives the spi_master enable/data handshake, captures the read-back word from each transfer, and reports done/error status for codec register bring-up.

---
 rtl/spi_command_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_spi_command_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_sequencer.sv
// Table-driven feeder for spi_master: walks a command ROM of transfer/delay entries.
// Optional done-timeout in WAIT_DONE is compiled in with `define SEQ_TIMEOUT_EN.
module spi_command_sequencer #(
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned CMD_ADDR_WIDTH = 6,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [TIMEOUT_WIDTH-1:0]    i_timeout_limit,
  output logic [CMD_ADDR_WIDTH-1:0]   o_cmd_addr,
  input  logic [SPI_DATA_WIDTH+1:0]   i_cmd_data,
  output logic                        o_spi_enable,
  output logic [SPI_DATA_WIDTH-1:0]   o_spi_data,
  input  logic [SPI_DATA_WIDTH-1:0]   i_spi_data,
  input  logic                        i_spi_done,
  input  logic                        i_spi_busy,
  output logic [SPI_DATA_WIDTH-1:0]   o_rx_data,
  output logic                        o_rx_valid,
  output logic [CMD_ADDR_WIDTH:0]     o_cmd_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error
);

  localparam int unsigned W     = SPI_DATA_WIDTH;
  localparam int unsigned AW    = CMD_ADDR_WIDTH;
  localparam int unsigned CNT_W = CMD_ADDR_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             enable_q, enable_d;
  logic [W-1:0]     tx_q, tx_d;
  logic [W-1:0]     rx_q, rx_d;
  logic             rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     delay_q, delay_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             advance;
  logic [W-1:0]     payload;

  assign payload = i_cmd_data[W-1:0];

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tout_q, tout_d;
  logic                     expired;

  // Limit of zero disables the timeout.
  assign expired = (i_timeout_limit != '0) &&
                   (tout_q == i_timeout_limit - TIMEOUT_WIDTH'(1));
`else
  logic unused_timeout;
  assign unused_timeout = ^i_timeout_limit;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      enable_q   <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      count_q    <= '0;
      delay_q    <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tout_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      enable_q   <= enable_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      count_q    <= count_d;
      delay_q    <= delay_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef SEQ_TIMEOUT_EN
      tout_q     <= tout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    enable_d   = 1'b0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_valid_d = 1'b0;
    count_d    = count_q;
    delay_d    = delay_q;
    last_d     = last_q;
    advance    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tout_d     = tout_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          count_d = '0;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        last_d = i_cmd_data[W+1];
        if (i_cmd_data[W]) begin
          delay_d = (payload == '0) ? W'(1) : payload;
          state_d = S_DELAY;
        end else if (!i_spi_busy) begin
          enable_d = 1'b1;
          tx_d     = payload;
          state_d  = S_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
          tout_d   = '0;
`endif
        end
      end
      S_WAIT_DONE: begin
        // A done coinciding with expiry still counts as success.
        if (i_spi_done) begin
          rx_d       = i_spi_data;
          rx_valid_d = 1'b1;
          count_d    = count_q + CNT_W'(1);
          advance    = 1'b1;
`ifdef SEQ_TIMEOUT_EN
        end else if (expired) begin
          state_d = S_ERROR;
        end else begin
          tout_d = tout_q + TIMEOUT_WIDTH'(1);
`endif
        end
      end
      // Counts payload..1, then one retire cycle at zero.
      S_DELAY: begin
        if (delay_q == '0) advance = 1'b1;
        else               delay_d = delay_q - W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Retire the entry; the last table slot ends the run without wrapping.
    if (advance) begin
      if (last_q || addr_q == LAST_ADDR) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_FETCH;
      end
    end

    busy_d  = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
              (state_d == S_WAIT_DONE) || (state_d == S_DELAY);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  assign o_cmd_addr   = addr_q;
  assign o_spi_enable = enable_q;
  assign o_spi_data   = tx_q;
  assign o_rx_data    = rx_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_cmd_count  = count_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
`ifdef SEQ_TIMEOUT_EN
  assign o_error      = error_q;
`else
  logic unused_error;
  assign unused_error = error_q;
  assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Bench for spi_command_sequencer: ROM model, spi_master model and rx/tx scoreboards.
module tb_spi_command_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 2;
  localparam int unsigned TW = 16;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_start = 1'b0;
  logic [TW-1:0]   i_timeout_limit = '0;
  logic [AW-1:0]   o_cmd_addr;
  logic [W+1:0]    i_cmd_data = '0;
  logic            o_spi_enable;
  logic [W-1:0]    o_spi_data;
  logic [W-1:0]    i_spi_data = '0;
  logic            i_spi_done = 1'b0;
  logic            i_spi_busy = 1'b0;
  logic [W-1:0]    o_rx_data;
  logic            o_rx_valid;
  logic [AW:0]     o_cmd_count;
  logic            o_busy;
  logic            o_done;
  logic            o_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W+1:0] rom [4];
  logic [W-1:0] tx_exp [$];
  logic [W-1:0] rx_exp [$];
  int           en_cyc [$];
  int           rxv_seen = 0;
  int           slow_at  = -1;
  int           slow_lat = 0;
  int           done_cnt = 0;
  logic [W-1:0] pend_rx  = '0;

  spi_command_sequencer #(
    .SPI_DATA_WIDTH(W), .CMD_ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_timeout_limit(i_timeout_limit), .o_cmd_addr(o_cmd_addr),
    .i_cmd_data(i_cmd_data), .o_spi_enable(o_spi_enable),
    .o_spi_data(o_spi_data), .i_spi_data(i_spi_data),
    .i_spi_done(i_spi_done), .i_spi_busy(i_spi_busy),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_cmd_count(o_cmd_count), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) i_cmd_data <= rom[o_cmd_addr];

  // spi_master model plus tx/rx scoreboard checks.
  always @(negedge clk) begin
    logic [W-1:0] e;
    i_spi_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        i_spi_done = 1'b1;
        i_spi_data = pend_rx;
        rx_exp.push_back(pend_rx);
      end
    end
    if (o_spi_enable) begin
      n_tests++;
      if (tx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL tx_payload: got enable with %h, required no enable", o_spi_data);
      end else begin
        e = tx_exp.pop_front();
        if (o_spi_data !== e) begin
          n_fail++;
          $display("FAIL tx_payload: got %h, required %h", o_spi_data, e);
        end
      end
      pend_rx  = 32'hA5A5_0000 + W'(en_cyc.size());
      done_cnt = (en_cyc.size() == slow_at) ? slow_lat : 4;
      en_cyc.push_back(cyc);
    end
    if (o_rx_valid) begin
      rxv_seen++;
      n_tests++;
      if (rx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rx_data: got pulse with %h, required no pulse", o_rx_data);
      end else begin
        e = rx_exp.pop_front();
        if (o_rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_data: got %h, required %h", o_rx_data, e);
        end
      end
    end
  end

  function automatic logic [W+1:0] ent(input bit last, input bit dly, input logic [W-1:0] p);
    return {last, dly, p};
  endfunction

  task automatic do_reset();
    @(negedge clk); i_reset = 1'b1;
    @(negedge clk); i_reset = 1'b0;
  endtask

  task automatic start_seq(output int c0);
    en_cyc.delete();
    slow_at = -1;
    @(negedge clk); i_start = 1'b1; c0 = cyc;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i = 0;
    while (!(o_done || o_error) && i < 2000) begin @(negedge clk); i++; end
    n_tests++;
    if (!(o_done || o_error)) begin
      n_fail++;
      $display("FAIL %s_end: got still busy after %0d cycles, required done or error", name, i);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    n_tests++;
    if ({o_busy, o_done, o_error, o_spi_enable, o_rx_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000", {o_busy, o_done, o_error, o_spi_enable, o_rx_valid});
    end
    n_tests++;
    if ({o_cmd_addr, o_cmd_count, o_rx_data, o_spi_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr %0d count %0d rx %h tx %h, required all 0", o_cmd_addr, o_cmd_count, o_rx_data, o_spi_data);
    end
  endtask

  task automatic test_three_entry();
    int c0;
    rom[0] = ent(0, 0, 32'h0000_4001);
    rom[1] = ent(0, 0, 32'h0000_4015);
    rom[2] = ent(1, 0, 32'h0000_8000);
    rom[3] = ent(0, 0, 32'hDEAD_BEEF);
    tx_exp.push_back(32'h0000_4001);
    tx_exp.push_back(32'h0000_4015);
    tx_exp.push_back(32'h0000_8000);
    start_seq(c0);
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL three_busy: got %b, required 1", o_busy); end
    wait_end("three");
    @(negedge clk);
    n_tests++;
    if (en_cyc.size() !== 3) begin n_fail++; $display("FAIL three_enables: got %0d, required 3", en_cyc.size()); end
    else begin
      n_tests++;
      if (en_cyc[0] - c0 !== 3) begin n_fail++; $display("FAIL three_latency: got %0d, required 3", en_cyc[0] - c0); end
    end
    n_tests++;
    if ({o_done, o_busy, o_error} !== 3'b100) begin n_fail++; $display("FAIL three_status: got %b, required 100", {o_done, o_busy, o_error}); end
    n_tests++;
    if (o_cmd_count !== 3'd3) begin n_fail++; $display("FAIL three_count: got %0d, required 3", o_cmd_count); end
    n_tests++;
    if (rx_exp.size() !== 0) begin n_fail++; $display("FAIL three_rx_left: got %0d pending, required 0", rx_exp.size()); end
  endtask

  task automatic test_delay();
    int c0;
    rom[0] = ent(0, 1, 32'd20);
    rom[1] = ent(1, 0, 32'h1234_5678);
    tx_exp.push_back(32'h1234_5678);
    start_seq(c0);
    wait_end("delay");
    @(negedge clk);
    n_tests++;
    if (en_cyc.size() !== 1) begin n_fail++; $display("FAIL delay_enables: got %0d, required 1", en_cyc.size()); end
    else begin
      n_tests++;
      if (en_cyc[0] - c0 !== 3 + 20 + 3) begin n_fail++; $display("FAIL delay_latency: got %0d, required 26", en_cyc[0] - c0); end
    end
    n_tests++;
    if (o_cmd_count !== 3'd1 || o_done !== 1'b1) begin n_fail++; $display("FAIL delay_count: got count %0d done %b, required 1 1", o_cmd_count, o_done); end
  endtask

  task automatic test_busy();
    int c0, cb;
    rom[0] = ent(1, 0, 32'h0000_CAFE);
    tx_exp.push_back(32'h0000_CAFE);
    i_spi_busy = 1'b1;
    start_seq(c0);
    repeat (11) @(negedge clk);
    n_tests++;
    if (en_cyc.size() !== 0) begin n_fail++; $display("FAIL busy_hold: got %0d enables, required 0", en_cyc.size()); end
    i_spi_busy = 1'b0; cb = cyc;
    wait_end("busy");
    @(negedge clk);
    n_tests++;
    if (en_cyc.size() !== 1) begin n_fail++; $display("FAIL busy_enables: got %0d, required 1", en_cyc.size()); end
    else begin
      n_tests++;
      if (en_cyc[0] !== cb + 1) begin n_fail++; $display("FAIL busy_release: got cycle %0d, required %0d", en_cyc[0], cb + 1); end
    end
  endtask

  task automatic test_no_last();
    int c0;
    for (int i = 0; i < 4; i++) begin
      rom[i] = ent(0, 0, 32'h10 + 32'(i));
      tx_exp.push_back(32'h10 + 32'(i));
    end
    start_seq(c0);
    wait_end("nolast");
    repeat (3) @(negedge clk);
    n_tests++;
    if (en_cyc.size() !== 4) begin n_fail++; $display("FAIL nolast_enables: got %0d, required 4", en_cyc.size()); end
    n_tests++;
    if (o_cmd_addr !== 2'd3 || o_cmd_count !== 3'd4) begin n_fail++; $display("FAIL nolast_end: got addr %0d count %0d, required 3 4", o_cmd_addr, o_cmd_count); end
    n_tests++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL nolast_status: got done %b busy %b, required 1 0", o_done, o_busy); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int c0, e1, i;
    rom[0] = ent(0, 0, 32'h1);
    rom[1] = ent(0, 0, 32'h2);
    rom[2] = ent(1, 0, 32'h3);
    tx_exp.push_back(32'h1);
    tx_exp.push_back(32'h2);
    i_timeout_limit = 16'd50;
    start_seq(c0);
    slow_at = 1; slow_lat = 0;
    i = 0;
    while (!o_error && i < 500) begin @(negedge clk); i++; end
    n_tests++;
    if (o_error !== 1'b1 || en_cyc.size() !== 2) begin
      n_fail++; $display("FAIL tout_error: got error %b enables %0d, required 1 2", o_error, en_cyc.size());
    end else begin
      e1 = en_cyc[1];
      n_tests++;
      if (cyc - e1 !== 50) begin n_fail++; $display("FAIL tout_time: got %0d cycles, required 50", cyc - e1); end
    end
    n_tests++;
    if (o_cmd_addr !== 2'd1 || o_cmd_count !== 3'd1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL tout_state: got addr %0d count %0d busy %b, required 1 1 0", o_cmd_addr, o_cmd_count, o_busy);
    end
    rom[0] = ent(1, 0, 32'h77);
    tx_exp.push_back(32'h77);
    start_seq(c0);
    n_tests++;
    if (o_cmd_addr !== 2'd0 || o_error !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL tout_restart: got addr %0d error %b busy %b, required 0 0 1", o_cmd_addr, o_error, o_busy);
    end
    wait_end("tout_restart");
    n_tests++;
    if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL tout_rerun: got done %b error %b, required 1 0", o_done, o_error); end
    i_timeout_limit = '0;
  endtask
`else
  task automatic test_timeout();
    int c0;
    rom[0] = ent(1, 0, 32'h1);
    tx_exp.push_back(32'h1);
    i_timeout_limit = 16'd5;
    start_seq(c0);
    slow_at = 0; slow_lat = 0;
    repeat (100) @(negedge clk);
    n_tests++;
    if (o_error !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL nowait_error: got error %b busy %b, required 0 1", o_error, o_busy); end
    do_reset();
    i_timeout_limit = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int c0, i, seen;
    rom[0] = ent(0, 0, 32'h21);
    rom[1] = ent(0, 0, 32'h22);
    rom[2] = ent(1, 0, 32'h23);
    for (int k = 0; k < 3; k++) tx_exp.push_back(32'h21 + 32'(k));
    start_seq(c0);
    slow_at = 2; slow_lat = 30;
    i = 0;
    while (en_cyc.size() < 3 && i < 500) begin @(negedge clk); i++; end
    n_tests++;
    if (en_cyc.size() !== 3) begin n_fail++; $display("FAIL rmid_reach: got %0d enables, required 3", en_cyc.size()); end
    repeat (5) @(negedge clk);
    seen = rxv_seen;
    do_reset();
    n_tests++;
    if ({o_busy, o_done, o_error, o_spi_enable, o_rx_valid, o_cmd_addr, o_cmd_count} !== '0) begin
      n_fail++; $display("FAIL rmid_after_reset: got busy %b addr %0d count %0d, required all 0", o_busy, o_cmd_addr, o_cmd_count);
    end
    repeat (35) @(negedge clk);
    n_tests++;
    if (rxv_seen !== seen) begin n_fail++; $display("FAIL rmid_late_done: got %0d rx pulses, required 0", rxv_seen - seen); end
    n_tests++;
    if ({o_busy, o_done, o_error, o_rx_data, o_cmd_count} !== '0) begin
      n_fail++; $display("FAIL rmid_idle: got busy %b done %b rx %h, required all 0", o_busy, o_done, o_rx_data);
    end
    rx_exp.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = '0;
    test_reset();
    test_three_entry();
    test_delay();
    test_busy();
    test_no_last();
    test_timeout();
    test_reset_mid();
    n_tests++;
    if (tx_exp.size() !== 0) begin n_fail++; $display("FAIL tx_left: got %0d pending, required 0", tx_exp.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
